motor_timer: RTL and testbench

- Consumer end of the keypad Input block's selection interface.
- Takes the one-hot Motor selection and the 3-digit BCD time (TValue2 = hundreds, TValue1 = tens, TValue0 = units) that Input publishes on Enter.
- Drives the selected motor for that many seconds, counting down in BCD, and exposes the remaining time for the display block.
- Sits between Input and the motor drivers and display.

---
 rtl/motor_timer_pkg.sv | 26 ++
 rtl/bcd_down_cnt3.sv | 53 +++++
 rtl/motor_timer.sv | 173 +++++++++++++++++
 tb/tb_motor_timer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/motor_timer_pkg.sv
// Shared definitions for the motor countdown timer: FSM state encoding,
// BCD digit limits, motor selection width and a one-hot check.
package motor_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int unsigned DIGIT_W   = 4;
  localparam logic [3:0]  DIGIT_MAX = 4'd9;
  localparam int unsigned MOTOR_W   = 6;

  // True when exactly one bit of the motor selection is set.
  function automatic logic is_onehot(input logic [MOTOR_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < MOTOR_W; i++) begin
      if (v[i]) n++;
    end
    return (n == 1);
  endfunction

endpackage

// File: rtl/bcd_down_cnt3.sv
// Three-digit BCD down counter with synchronous clear, load and decrement
// (priority in that order). Decrementing at 000 holds the value.
module bcd_down_cnt3
  import motor_timer_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        load,
  input  logic [11:0] load_val,
  input  logic        dec,
  output logic [11:0] cnt,
  output logic        zero
);

  logic [11:0] cnt_q;
  logic [11:0] cnt_d;
  logic [11:0] cnt_dec;

  // BCD decrement with digit borrows: units 0->9 borrows from tens, tens 0->9 from hundreds.
  always_comb begin
    cnt_dec = cnt_q;
    if (cnt_q[3:0] != 4'd0) begin
      cnt_dec[3:0] = cnt_q[3:0] - 4'd1;
    end else begin
      cnt_dec[3:0] = DIGIT_MAX;
      if (cnt_q[7:4] != 4'd0) begin
        cnt_dec[7:4] = cnt_q[7:4] - 4'd1;
      end else begin
        cnt_dec[7:4]  = DIGIT_MAX;
        cnt_dec[11:8] = cnt_q[11:8] - 4'd1;
      end
    end
  end

  // Next-value selection.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)                    cnt_d = '0;
    else if (load)              cnt_d = load_val;
    else if (dec && !zero)      cnt_d = cnt_dec;
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == 12'h000);

endmodule

// File: rtl/motor_timer.sv
// Motor countdown timer: loads a one-hot motor selection and a 3-digit BCD
// time when the selection changes, drives the motor while counting down one
// BCD step per TICK_DIV clocks, supports pause, and flags rejected loads.
// Optional: define MOTOR_TIMER_WARN_EN to add the Warn output (last 9 s).
module motor_timer
  import motor_timer_pkg::*;
#(
  parameter int unsigned TICK_DIV = 100000000,
  parameter int unsigned CNT_W    = 27
) (
  input  logic       sysclk,
  input  logic       rst,
  input  logic [5:0] Motor,
  input  logic [3:0] TValue0,
  input  logic [3:0] TValue1,
  input  logic [3:0] TValue2,
  input  logic       Pause,
  output logic [5:0] MotorOut,
  output logic [3:0] Remain0,
  output logic [3:0] Remain1,
  output logic [3:0] Remain2,
  output logic       Busy,
  output logic       Done,
`ifdef MOTOR_TIMER_WARN_EN
  output logic       Warn,
`endif
  output logic       Err
);

  state_e state_q, state_d;

  logic [MOTOR_W-1:0] motor_prev_q;
  logic [MOTOR_W-1:0] sel_q, sel_d;
  logic [CNT_W-1:0]   pre_q, pre_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               zero_pend_q, zero_pend_d;

  logic        load_req, clear_req, load_ok, tick, t_zero;
  logic [11:0] tval, remain;
  logic        cnt_clr, cnt_load, cnt_dec, cnt_zero;

  assign tval      = {TValue2, TValue1, TValue0};
  assign load_req  = (Motor != motor_prev_q) && (Motor != '0);
  assign clear_req = (Motor == '0) && (motor_prev_q != '0);
  assign load_ok   = is_onehot(Motor) && (TValue0 <= DIGIT_MAX) &&
                     (TValue1 <= DIGIT_MAX) && (TValue2 <= DIGIT_MAX);
  assign t_zero    = (tval == 12'h000);
  assign tick      = (pre_q == CNT_W'(TICK_DIV - 1));

  bcd_down_cnt3 u_cnt (
    .clk      (sysclk),
    .rst_n    (rst),
    .clr      (cnt_clr),
    .load     (cnt_load),
    .load_val (tval),
    .dec      (cnt_dec),
    .cnt      (remain),
    .zero     (cnt_zero)
  );

  // FSM state register.
  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // FSM next state: clear > load > pause > tick. A rejected load holds the state.
  always_comb begin
    state_d = state_q;
    if (clear_req) begin
      state_d = ST_IDLE;
    end else if (load_req) begin
      if (load_ok) state_d = t_zero ? ST_DONE : ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (Pause)                           state_d = ST_PAUSE;
          else if (tick && remain == 12'h001)  state_d = ST_DONE;
        end
        ST_PAUSE: if (!Pause) state_d = ST_RUN;
        default: ;
      endcase
    end
  end

  // FSM outputs: motor driven only in RUN; busy in RUN or PAUSE.
  always_comb begin
    MotorOut = (state_q == ST_RUN) ? sel_q : '0;
    Busy     = (state_q == ST_RUN) || (state_q == ST_PAUSE);
  end

  // Datapath control. A tick landing on the pause edge wraps the prescaler
  // without decrementing so it is dropped rather than replayed on resume.
  // A zero-time load arms zero_pend so Done fires on the following edge.
  always_comb begin
    pre_d       = pre_q;
    sel_d       = sel_q;
    err_d       = err_q;
    done_d      = 1'b0;
    zero_pend_d = 1'b0;
    cnt_clr     = 1'b0;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;
    if (clear_req) begin
      cnt_clr = 1'b1;
      pre_d   = '0;
      sel_d   = '0;
    end else if (load_req) begin
      if (load_ok) begin
        cnt_load    = 1'b1;
        pre_d       = '0;
        sel_d       = Motor;
        err_d       = 1'b0;
        zero_pend_d = t_zero;
      end else begin
        err_d = 1'b1;
      end
    end else begin
      case (state_q)
        ST_RUN: begin
          if (tick) begin
            pre_d = '0;
            if (!Pause) begin
              cnt_dec = 1'b1;
              done_d  = (remain == 12'h001);
            end
          end else if (!Pause) begin
            pre_d = pre_q + CNT_W'(1);
          end
        end
        ST_DONE: done_d = zero_pend_q;
        default: ;
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      motor_prev_q <= '0;
      sel_q        <= '0;
      pre_q        <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      zero_pend_q  <= 1'b0;
    end else begin
      motor_prev_q <= Motor;
      sel_q        <= sel_d;
      pre_q        <= pre_d;
      done_q       <= done_d;
      err_q        <= err_d;
      zero_pend_q  <= zero_pend_d;
    end
  end

  assign Remain0 = remain[3:0];
  assign Remain1 = remain[7:4];
  assign Remain2 = remain[11:8];
  assign Done    = done_q;
  assign Err     = err_q;

`ifdef MOTOR_TIMER_WARN_EN
  // Warning while active and the hundreds and tens digits are both zero.
  always_comb begin
    Warn = Busy && (remain[11:4] == 8'h00);
  end
`endif

  logic unused_ok;
  assign unused_ok = cnt_zero;

endmodule

// File: tb/tb_motor_timer.sv
// Directed bench for motor_timer with TICK_DIV=4. Inputs change and outputs
// are sampled on the falling clock edge.
module tb_motor_timer;

  logic       sysclk;
  logic       rst;
  logic [5:0] Motor;
  logic [3:0] TValue0, TValue1, TValue2;
  logic       Pause;
  logic [5:0] MotorOut;
  logic [3:0] Remain0, Remain1, Remain2;
  logic       Busy, Done, Err;
`ifdef MOTOR_TIMER_WARN_EN
  logic       Warn;
`endif

  logic [11:0] remain;
  assign remain = {Remain2, Remain1, Remain0};

  int pass_cnt  = 0;
  int total_cnt = 0;

  motor_timer #(.TICK_DIV(4), .CNT_W(3)) dut (
    .sysclk   (sysclk),
    .rst      (rst),
    .Motor    (Motor),
    .TValue0  (TValue0),
    .TValue1  (TValue1),
    .TValue2  (TValue2),
    .Pause    (Pause),
    .MotorOut (MotorOut),
    .Remain0  (Remain0),
    .Remain1  (Remain1),
    .Remain2  (Remain2),
    .Busy     (Busy),
    .Done     (Done),
`ifdef MOTOR_TIMER_WARN_EN
    .Warn     (Warn),
`endif
    .Err      (Err)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  task automatic step(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  task automatic set_time(input logic [11:0] t);
    TValue2 = t[11:8];
    TValue1 = t[7:4];
    TValue0 = t[3:0];
  endtask

  task automatic test_reset();
    rst = 1'b0; Motor = '0; Pause = 1'b0; set_time(12'h000);
    step(2);
    total_cnt++;
    if ({MotorOut, remain, Busy, Done, Err} !== 21'd0)
      $display("FAIL reset_outputs got=%h exp=0", {MotorOut, remain, Busy, Done, Err});
    else pass_cnt++;
    rst = 1'b1;
    step(1);
  endtask

  task automatic test_basic();
    int done_seen;
    Motor = 6'b010000; set_time(12'h008);
    step(1);
    total_cnt++;
    if ({MotorOut, remain, Busy} !== {6'b010000, 12'h008, 1'b1})
      $display("FAIL basic_load got=%b/%h/%b exp=010000/008/1", MotorOut, remain, Busy);
    else pass_cnt++;
    step(3);
    total_cnt++;
    if (remain !== 12'h008) $display("FAIL basic_hold3 got=%h exp=008", remain);
    else pass_cnt++;
    step(1);
    total_cnt++;
    if (remain !== 12'h007) $display("FAIL basic_first_dec got=%h exp=007", remain);
    else pass_cnt++;
    step(27);
    total_cnt++;
    if ({MotorOut, remain, Done} !== {6'b010000, 12'h001, 1'b0})
      $display("FAIL basic_at_001 got=%b/%h/%b exp=010000/001/0", MotorOut, remain, Done);
    else pass_cnt++;
    step(1);
    total_cnt++;
    if ({MotorOut, remain, Busy, Done} !== {6'b000000, 12'h000, 1'b0, 1'b1})
      $display("FAIL basic_done got=%b/%h/%b/%b exp=000000/000/0/1", MotorOut, remain, Busy, Done);
    else pass_cnt++;
    done_seen = 0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      if (Done) done_seen++;
    end
    total_cnt++;
    if (done_seen !== 0) $display("FAIL basic_done_width got=%0d extra exp=0", done_seen);
    else pass_cnt++;
    Motor = '0;
    step(1);
  endtask

  task automatic test_borrow_pause();
    Motor = 6'b000001; set_time(12'h100);
    step(1);
    total_cnt++;
    if (remain !== 12'h100) $display("FAIL bp_load got=%h exp=100", remain);
    else pass_cnt++;
    step(4);
    total_cnt++;
    if (remain !== 12'h099) $display("FAIL bp_borrow got=%h exp=099", remain);
    else pass_cnt++;
    step(4);
    total_cnt++;
    if (remain !== 12'h098) $display("FAIL bp_second got=%h exp=098", remain);
    else pass_cnt++;
    step(2);
    Pause = 1'b1;
    step(1);
    total_cnt++;
    if ({MotorOut, Busy, remain} !== {6'b000000, 1'b1, 12'h098})
      $display("FAIL bp_pause_enter got=%b/%b/%h exp=000000/1/098", MotorOut, Busy, remain);
    else pass_cnt++;
    step(9);
    total_cnt++;
    if ({MotorOut, Busy, remain} !== {6'b000000, 1'b1, 12'h098})
      $display("FAIL bp_pause_hold got=%b/%b/%h exp=000000/1/098", MotorOut, Busy, remain);
    else pass_cnt++;
    Pause = 1'b0;
    step(1);
    total_cnt++;
    if ({MotorOut, remain} !== {6'b000001, 12'h098})
      $display("FAIL bp_resume got=%b/%h exp=000001/098", MotorOut, remain);
    else pass_cnt++;
    step(2);
    total_cnt++;
    if (remain !== 12'h097) $display("FAIL bp_partial_kept got=%h exp=097", remain);
    else pass_cnt++;
    Motor = '0;
    step(1);
    total_cnt++;
    if ({MotorOut, remain, Busy} !== {6'b000000, 12'h000, 1'b0})
      $display("FAIL bp_clear got=%b/%h/%b exp=000000/000/0", MotorOut, remain, Busy);
    else pass_cnt++;
  endtask

  task automatic test_err();
    Motor = 6'b000011; set_time(12'h005);
    step(1);
    total_cnt++;
    if ({Err, MotorOut, remain, Busy} !== {1'b1, 6'b000000, 12'h000, 1'b0})
      $display("FAIL err_multi got=%b/%b/%h/%b exp=1/000000/000/0", Err, MotorOut, remain, Busy);
    else pass_cnt++;
    Motor = '0;
    step(1);
    total_cnt++;
    if (Err !== 1'b1) $display("FAIL err_sticky_clear got=%b exp=1", Err);
    else pass_cnt++;
    Motor = 6'b001000; set_time(12'h0A3);
    step(1);
    total_cnt++;
    if ({Err, MotorOut, remain} !== {1'b1, 6'b000000, 12'h000})
      $display("FAIL err_digit got=%b/%b/%h exp=1/000000/000", Err, MotorOut, remain);
    else pass_cnt++;
    Motor = 6'b000100; set_time(12'h005);
    step(1);
    total_cnt++;
    if ({Err, MotorOut, remain} !== {1'b0, 6'b000100, 12'h005})
      $display("FAIL err_valid_clears got=%b/%b/%h exp=0/000100/005", Err, MotorOut, remain);
    else pass_cnt++;
    Motor = 6'b000110; set_time(12'h777);
    step(1);
    total_cnt++;
    if ({Err, MotorOut, remain} !== {1'b1, 6'b000100, 12'h005})
      $display("FAIL err_in_run got=%b/%b/%h exp=1/000100/005", Err, MotorOut, remain);
    else pass_cnt++;
    Motor = '0;
    step(1);
  endtask

  task automatic test_restart();
    Motor = 6'b000001; set_time(12'h005);
    step(3);
    Motor = 6'b000010; set_time(12'h020);
    step(1);
    total_cnt++;
    if ({MotorOut, remain} !== {6'b000010, 12'h020})
      $display("FAIL rs_reload got=%b/%h exp=000010/020", MotorOut, remain);
    else pass_cnt++;
    step(3);
    total_cnt++;
    if (remain !== 12'h020) $display("FAIL rs_prescaler_restart got=%h exp=020", remain);
    else pass_cnt++;
    step(1);
    total_cnt++;
    if (remain !== 12'h019) $display("FAIL rs_first_dec got=%h exp=019", remain);
    else pass_cnt++;
    set_time(12'h007);
    step(4);
    total_cnt++;
    if (remain !== 12'h018) $display("FAIL rs_time_latched got=%h exp=018", remain);
    else pass_cnt++;
    Motor = '0;
    step(1);
    total_cnt++;
    if ({MotorOut, remain, Busy, Done} !== {6'b000000, 12'h000, 1'b0, 1'b0})
      $display("FAIL rs_clear got=%b/%h/%b/%b exp=000000/000/0/0", MotorOut, remain, Busy, Done);
    else pass_cnt++;
  endtask

  task automatic test_zero_load();
    int done_seen;
    int motor_seen;
    Motor = 6'b100000; set_time(12'h000);
    done_seen = 0; motor_seen = 0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      if (Done) done_seen++;
      if (MotorOut != '0 || Busy) motor_seen++;
    end
    total_cnt++;
    if (done_seen !== 1) $display("FAIL zero_done_pulses got=%0d exp=1", done_seen);
    else pass_cnt++;
    total_cnt++;
    if (motor_seen !== 0) $display("FAIL zero_motor_active got=%0d exp=0", motor_seen);
    else pass_cnt++;
    Motor = '0;
    step(1);
  endtask

  task automatic test_async_reset();
    Motor = 6'b001000; set_time(12'h050);
    step(2);
    total_cnt++;
    if ({MotorOut, Busy} !== {6'b001000, 1'b1})
      $display("FAIL ar_running got=%b/%b exp=001000/1", MotorOut, Busy);
    else pass_cnt++;
    #2 rst = 1'b0;
    #1;
    total_cnt++;
    if ({MotorOut, remain, Busy, Done, Err} !== 21'd0)
      $display("FAIL ar_immediate got=%h exp=0", {MotorOut, remain, Busy, Done, Err});
    else pass_cnt++;
    Motor = '0;
    step(1);
    rst = 1'b1;
    step(1);
  endtask

`ifdef MOTOR_TIMER_WARN_EN
  task automatic test_warn();
    int guard;
    Motor = 6'b000001; set_time(12'h012);
    step(1);
    step(11);
    total_cnt++;
    if ({remain, Warn} !== {12'h010, 1'b0})
      $display("FAIL warn_at_010 got=%h/%b exp=010/0", remain, Warn);
    else pass_cnt++;
    step(1);
    total_cnt++;
    if ({remain, Warn} !== {12'h009, 1'b1})
      $display("FAIL warn_at_009 got=%h/%b exp=009/1", remain, Warn);
    else pass_cnt++;
    Pause = 1'b1;
    step(2);
    total_cnt++;
    if ({Busy, MotorOut, Warn} !== {1'b1, 6'b000000, 1'b1})
      $display("FAIL warn_pause got=%b/%b/%b exp=1/000000/1", Busy, MotorOut, Warn);
    else pass_cnt++;
    Pause = 1'b0;
    guard = 0;
    while (!Done && guard < 60) begin
      step(1);
      guard++;
    end
    total_cnt++;
    if ({Done, Warn} !== {1'b1, 1'b0})
      $display("FAIL warn_done got=%b/%b exp=1/0 after %0d cycles", Done, Warn, guard);
    else pass_cnt++;
    Motor = '0;
    step(1);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_borrow_pause();
    test_err();
    test_restart();
    test_zero_load();
    test_async_reset();
`ifdef MOTOR_TIMER_WARN_EN
    test_warn();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
